iic_bus_arbiter: RTL
====================

Name: iic_bus_arbiter

Overview:
- Round-robin arbiter sharing one IIC_Driver write port among NUM_REQ command sources.
- Typical sources: OLED command/data sequencers and sensor configuration writers.
- Each source presents a 24-bit write command {slave[23:16], reg[15:8], data[7:0]}. The arbiter grants one source per transfer, forwards the command to the driver, and returns a completion or timeout pulse to that source.
- Sits between the per-function sequencers and the single IIC_Driver instance of the OLED/sensor top level.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT, 5_000_000: maximum cycles in WAIT_DONE before the transfer is aborted. Counter width is $clog2(TIMEOUT+1).

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester level write request; held high until its done or timeout_err pulse
- req_data  in  24*NUM_REQ  packed commands; requester i at [24*i+23 : 24*i]
- grant  out  NUM_REQ  one-hot, registered; current owner of the bus
- done  out  NUM_REQ  one-cycle pulse to the owner on successful transfer
- timeout_err  out  NUM_REQ  one-cycle pulse to the owner on aborted transfer
- iic_write_req  out  1  level write request to IIC_Driver
- iic_write_data  out  24  latched command {slave, reg, data} to IIC_Driver
- iic_write_done  in  1  driver completion pulse

Behaviour:
- Reset (async, rst_n=0): state=IDLE; grant, done, timeout_err, iic_write_req = 0; iic_write_data=0; timeout counter=0; last_grant=NUM_REQ-1, so requester 0 wins first.
- Reset mid-transfer: same values immediately. The driver sees req drop, and no done pulse is issued.
- State machine: IDLE -> WAIT_DONE -> RELEASE -> IDLE.
- IDLE:
  - If any req bit is set, select the first set bit scanning from last_grant+1 upward, modulo NUM_REQ.
  - Next edge: grant[sel]=1, last_grant=sel, iic_write_data=req_data[sel], iic_write_req=1, counter cleared, go to WAIT_DONE.
  - Latency: req to iic_write_req is 1 cycle.
- WAIT_DONE:
  - iic_write_req and iic_write_data are held constant.
  - Changes on req_data or req during the transfer are ignored.
  - Counter increments each cycle.
  - iic_write_done=1: next edge pulses done[last_grant], clears grant and iic_write_req, goes to RELEASE.
  - Otherwise, counter==TIMEOUT-1: next edge pulses timeout_err[last_grant], clears grant and iic_write_req, goes to RELEASE.
  - If iic_write_done and timeout coincide, done wins.
- RELEASE:
  - One cycle with iic_write_req=0, guaranteeing the driver sees a low gap.
  - done and timeout_err return to 0.
  - Then IDLE. Arbitration is evaluated in IDLE only, never in RELEASE.
- Requester dropping req during WAIT_DONE: the transfer still completes and done is still pulsed.
- Requester re-use: a requester holding req high after done is treated as a new request. It must present its next req_data by the IDLE cycle, i.e. 2 cycles after the done pulse.
- Fairness: one transfer per grant, so back-to-back requesters interleave. Worst-case wait is (NUM_REQ-1) transfers.
- Invariants:
  - grant is always one-hot or zero.
  - At most one bit of done|timeout_err is set, and only to last_grant.
  - iic_write_req=1 exactly when grant!=0.
- iic_write_done received outside WAIT_DONE is ignored.

Test Plan:
- Reset, then req=4'b0001 with req_data[23:0]=24'h78_00_AE: iic_write_req rises 1 cycle later with iic_write_data=24'h7800AE and grant=0001. Drive iic_write_done at cycle 40: done[0] pulses 1 cycle later, iic_write_req is low for at least 1 cycle.
- req=4'b1111 held continuously, driver completing each transfer after 10 cycles: grant order is 0,1,2,3,0,1 with exactly one done pulse per grant.
- req_data[0] changed from 24'h780040 to 24'h7840FF mid-transfer: iic_write_data stays 24'h780040 until done.
- TIMEOUT=100, no iic_write_done: timeout_err[owner] pulses 100 cycles after grant, and the next requester in rotation is granted 2 cycles later.
- rst_n pulsed low while in WAIT_DONE: all outputs 0 asynchronously, no done pulse, and after release requester 0 has priority again.
- iic_write_done asserted on the same cycle the counter reaches TIMEOUT-1: done pulses, timeout_err stays 0.

Source files
------------

// File: rtl/iic_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : iic_bus_arbiter                                               |
// | Purpose  : Round-robin arbiter that shares one IIC_Driver write port     |
// |            among NUM_REQ command sources. It grants one source per       |
// |            transfer, forwards the latched 24-bit command                 |
// |            {slave, reg, data} and returns a done or timeout_err pulse    |
// |            to the owner.                                                 |
// | Ports    : sys_clk, rst_n            clock, async active-low reset       |
// |            req[NUM_REQ]              level requests from the sources     |
// |            req_data[24*NUM_REQ]      packed commands, source i at        |
// |                                      [24*i+23 : 24*i]                    |
// |            grant[NUM_REQ]            one-hot current bus owner           |
// |            done / timeout_err        one-cycle pulses to the owner       |
// |            iic_write_req/_data       level request + command to driver   |
// |            iic_write_done            driver completion pulse             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module iic_bus_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 5_000_000
) (
   input  logic                   sys_clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [24*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]     grant,
   output logic [NUM_REQ-1:0]     done,
   output logic [NUM_REQ-1:0]     timeout_err,
   output logic                   iic_write_req,
   output logic [23:0]            iic_write_data,
   input  logic                   iic_write_done
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CW-1:0] C_CNT_LAST  = CW'(TIMEOUT - 1);
   localparam logic [LW-1:0] C_LAST_INIT = LW'(NUM_REQ - 1);
   localparam logic [LW:0]   C_NUM_REQ   = (LW+1)'(NUM_REQ);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_DONE = 2'd1,
      S_RELEASE   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [NUM_REQ-1:0]   terr_q, terr_d;
   logic                 wreq_q, wreq_d;
   logic [23:0]          wdata_q, wdata_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [LW-1:0]        last_q, last_d;

   logic [23:0]          w_cmd [NUM_REQ];
   logic                 w_found;
   logic [LW-1:0]        w_sel;
   logic [NUM_REQ-1:0]   w_sel_oh;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_cmd[gi] = req_data[24*gi +: 24];
      end
   endgenerate

   // Round-robin pick: scan last_grant+1, last_grant+2, ... wrapping modulo
   // NUM_REQ. The candidate sum is one bit wider so the wrap is a plain
   // subtract; last_q + NUM_REQ never exceeds 2*NUM_REQ-1.
   always_comb begin : p_arb
      logic [LW:0] cand;
      w_found = 1'b0;
      w_sel   = last_q;
      cand    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, last_q} + (LW+1)'(k);
         if (cand >= C_NUM_REQ) begin
            cand = cand - C_NUM_REQ;
         end
         if (!w_found && req[cand[LW-1:0]]) begin
            w_found = 1'b1;
            w_sel   = cand[LW-1:0];
         end
      end
   end

   assign w_sel_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      done_d  = '0;
      terr_d  = '0;
      wreq_d  = wreq_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (w_found) begin
               grant_d = w_sel_oh;
               last_d  = w_sel;
               wdata_d = w_cmd[w_sel];
               wreq_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            cnt_d = cnt_q + CW'(1);
            // grant_q is one-hot on last_grant, so it is the pulse pattern.
            // Completion is checked first so it wins over a coincident timeout.
            if (iic_write_done) begin
               done_d  = grant_q;
               grant_d = '0;
               wreq_d  = 1'b0;
               state_d = S_RELEASE;
            end else if (cnt_q == C_CNT_LAST) begin
               terr_d  = grant_q;
               grant_d = '0;
               wreq_d  = 1'b0;
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         done_q  <= '0;
         terr_q  <= '0;
         wreq_q  <= 1'b0;
         wdata_q <= '0;
         cnt_q   <= '0;
         last_q  <= C_LAST_INIT;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         terr_q  <= terr_d;
         wreq_q  <= wreq_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   assign grant          = grant_q;
   assign done           = done_q;
   assign timeout_err    = terr_q;
   assign iic_write_req  = wreq_q;
   assign iic_write_data = wdata_q;

endmodule
`default_nettype wire
